alu_arbiter: RTL and testbench

- Shares one combinational ALU (operands rrs1/rrs2/imm, decode instr_type/funct3/funct7, result w_res) between NREQ requesters, e.g. the execute stage and the branch/address unit.
- Per-requester valid/ready request channel; round-robin grant; operands registered before the ALU; result registered and returned on a per-requester valid/ready response channel.
- One operation in flight at a time.

---
 rtl/alu_arb_if.sv | 33 +++
 rtl/alu_arbiter.sv | 141 ++++++++++++++
 tb/tb_alu_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arb_if.sv
// Request/response bus between requesters and the shared-ALU arbiter.
// Decode fields and operands are packed per requester: slice i of each vector
// belongs to requester i.
interface alu_arb_if #(
    parameter int NREQ = 2,
    parameter int XLEN = 32
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*5-1:0]    req_instr_type;
    logic [NREQ*3-1:0]    req_funct3;
    logic [NREQ*7-1:0]    req_funct7;
    logic [NREQ*XLEN-1:0] req_rrs1;
    logic [NREQ*XLEN-1:0] req_rrs2;
    logic [NREQ*XLEN-1:0] req_imm;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_ready;
    logic [XLEN-1:0]      rsp_res;

    // arbiter side
    modport slave (
        input  req_valid, req_instr_type, req_funct3, req_funct7,
        input  req_rrs1, req_rrs2, req_imm, rsp_ready,
        output req_ready, rsp_valid, rsp_res
    );

    // requester side
    modport master (
        output req_valid, req_instr_type, req_funct3, req_funct7,
        output req_rrs1, req_rrs2, req_imm, rsp_ready,
        input  req_ready, rsp_valid, rsp_res
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NREQ requesters.
// One operation in flight: IDLE (arbitrate) -> EXEC (ALU evaluates the op
// register) -> RESP (hold result until the owner takes it).
// Optional macro ALU_ARB_BYPASS_EN: re-arbitrate in the cycle the response
// handshake completes, going RESP -> EXEC directly (one op per 2 cycles).
module alu_arbiter #(
    parameter int NREQ = 2,
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RST,
    alu_arb_if.slave        bus,
    output logic [4:0]      alu_instr_type,
    output logic [2:0]      alu_funct3,
    output logic [6:0]      alu_funct7,
    output logic [XLEN-1:0] alu_rrs1,
    output logic [XLEN-1:0] alu_rrs2,
    output logic [XLEN-1:0] alu_imm,
    input  logic [XLEN-1:0] alu_res,
    output logic            busy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   owner_q;
    logic [PW-1:0]   win, scan_p;
    int              scan_idx;
    logic            found, rsp_fire, arb_en, accept;

    logic [4:0]      type_q, sel_type;
    logic [2:0]      f3_q, sel_f3;
    logic [6:0]      f7_q, sel_f7;
    logic [XLEN-1:0] rrs1_q, rrs2_q, imm_q, res_q;
    logic [XLEN-1:0] sel_rrs1, sel_rrs2, sel_imm;

    // first valid requester starting from rr_ptr, wrapping mod NREQ
    always_comb begin
        found    = 1'b0;
        win      = '0;
        scan_idx = 0;
        scan_p   = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = (int'(rr_ptr_q) + k) % NREQ;
            scan_p   = PW'(scan_idx);
            if (!found && bus.req_valid[scan_p]) begin
                found = 1'b1;
                win   = scan_p;
            end
        end
        rr_ptr_d = PW'((int'(win) + 1) % NREQ);
    end

    // winner's payload mux
    always_comb begin
        sel_type = '0;
        sel_f3   = '0;
        sel_f7   = '0;
        sel_rrs1 = '0;
        sel_rrs2 = '0;
        sel_imm  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == PW'(i)) begin
                sel_type = bus.req_instr_type[5*i +: 5];
                sel_f3   = bus.req_funct3[3*i +: 3];
                sel_f7   = bus.req_funct7[7*i +: 7];
                sel_rrs1 = bus.req_rrs1[XLEN*i +: XLEN];
                sel_rrs2 = bus.req_rrs2[XLEN*i +: XLEN];
                sel_imm  = bus.req_imm[XLEN*i +: XLEN];
            end
        end
    end

    assign rsp_fire = (state_q == RESP) && bus.rsp_ready[owner_q];

`ifdef ALU_ARB_BYPASS_EN
    assign arb_en = !RST && ((state_q == IDLE) || rsp_fire);
`else
    assign arb_en = !RST && (state_q == IDLE);
`endif

    assign accept = arb_en && found;

    // next state plus one-hot ready/valid strobes
    always_comb begin
        state_d       = state_q;
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        if (accept) bus.req_ready[win] = 1'b1;
        case (state_q)
            IDLE: if (accept) state_d = EXEC;
            EXEC: state_d = RESP;
            RESP: begin
                bus.rsp_valid[owner_q] = 1'b1;
                if (rsp_fire) state_d = accept ? EXEC : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state, pointer, op and result registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            type_q   <= '0;
            f3_q     <= '0;
            f7_q     <= '0;
            rrs1_q   <= '0;
            rrs2_q   <= '0;
            imm_q    <= '0;
            res_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q  <= win;
                rr_ptr_q <= rr_ptr_d;
                type_q   <= sel_type;
                f3_q     <= sel_f3;
                f7_q     <= sel_f7;
                rrs1_q   <= sel_rrs1;
                rrs2_q   <= sel_rrs2;
                imm_q    <= sel_imm;
            end
            if (state_q == EXEC) res_q <= alu_res;
        end
    end

    // ALU inputs come straight from the op register so they stay stable
    assign alu_instr_type = type_q;
    assign alu_funct3     = f3_q;
    assign alu_funct7     = f7_q;
    assign alu_rrs1       = rrs1_q;
    assign alu_rrs2       = rrs2_q;
    assign alu_imm        = imm_q;
    assign bus.rsp_res    = res_q;
    assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: NREQ=2 instance for reset, single op,
// contention, backpressure and mid-op reset; NREQ=3 instance for fairness
// and accept spacing (2 cycles with ALU_ARB_BYPASS_EN, else 3).
module tb_alu_arbiter;
    localparam int XLEN = 32;
    localparam logic [4:0] OP_IMM = 5'b00100;
    localparam logic [4:0] OP     = 5'b01100;
`ifdef ALU_ARB_BYPASS_EN
    localparam int         GAP     = 2;
    localparam logic [1:0] BYP_RDY = 2'b10;
`else
    localparam int         GAP     = 3;
    localparam logic [1:0] BYP_RDY = 2'b00;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    alu_arb_if #(.NREQ(2), .XLEN(XLEN)) b2();
    alu_arb_if #(.NREQ(3), .XLEN(XLEN)) b3();

    logic [4:0]      t2, t3;
    logic [2:0]      f3_2, f3_3;
    logic [6:0]      f7_2, f7_3;
    logic [XLEN-1:0] a2, bb2, i2, r2, a3, bb3, i3, r3;
    logic            busy2, busy3;

    alu_arbiter #(.NREQ(2), .XLEN(XLEN)) u_dut2 (
        .CLK(CLK), .RST(RST), .bus(b2),
        .alu_instr_type(t2), .alu_funct3(f3_2), .alu_funct7(f7_2),
        .alu_rrs1(a2), .alu_rrs2(bb2), .alu_imm(i2),
        .alu_res(r2), .busy(busy2)
    );

    alu_arbiter #(.NREQ(3), .XLEN(XLEN)) u_dut3 (
        .CLK(CLK), .RST(RST), .bus(b3),
        .alu_instr_type(t3), .alu_funct3(f3_3), .alu_funct7(f7_3),
        .alu_rrs1(a3), .alu_rrs2(bb3), .alu_imm(i3),
        .alu_res(r3), .busy(busy3)
    );

    // reference ALU: ADDI, ADD, SUB; anything else yields 0
    function automatic logic [XLEN-1:0] alu_m(input logic [4:0] t, input logic [2:0] f3,
                                              input logic [6:0] f7, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b, input logic [XLEN-1:0] imm);
        if (t == OP_IMM && f3 == 3'b000) return a + imm;
        if (t == OP && f3 == 3'b000) return f7[5] ? a - b : a + b;
        return '0;
    endfunction

    assign r2 = alu_m(t2, f3_2, f7_2, a2, bb2, i2);
    assign r3 = alu_m(t3, f3_3, f7_3, a3, bb3, i3);

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req2(input int i, input logic [4:0] t, input logic [6:0] f7,
                            input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                            input logic [XLEN-1:0] imm);
        b2.req_instr_type[5*i +: 5]  = t;
        b2.req_funct3[3*i +: 3]      = 3'b000;
        b2.req_funct7[7*i +: 7]      = f7;
        b2.req_rrs1[XLEN*i +: XLEN]  = a;
        b2.req_rrs2[XLEN*i +: XLEN]  = b;
        b2.req_imm[XLEN*i +: XLEN]   = imm;
    endtask

    task automatic do_reset();
        b2.req_valid = '0;
        b2.rsp_ready = '0;
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    int grant[9];
    int gcyc[9];
    int ng;
    int gi;

    initial begin
        b2.req_valid = '0; b2.rsp_ready = '0;
        b2.req_instr_type = '0; b2.req_funct3 = '0; b2.req_funct7 = '0;
        b2.req_rrs1 = '0; b2.req_rrs2 = '0; b2.req_imm = '0;
        b3.req_valid = '0; b3.rsp_ready = '0;
        b3.req_instr_type = '0; b3.req_funct3 = '0; b3.req_funct7 = '0;
        b3.req_rrs1 = '0; b3.req_rrs2 = '0; b3.req_imm = '0;

        // reset: a pending request must not be acknowledged or latched
        RST = 1'b1;
        set_req2(0, OP_IMM, 7'd0, 32'd99, 32'd0, 32'd1);
        b2.req_valid = 2'b01;
        #1;
        chk("rst_req_ready", b2.req_ready, 2'b00);
        tick();
        chk("rst_alu_rrs1", a2, 0);
        chk("rst_busy", busy2, 0);
        chk("rst_rsp_valid", b2.rsp_valid, 2'b00);
        chk("rst_req_ready2", b2.req_ready, 2'b00);
        tick();

        // single ADDI 5+7 from requester 0
        RST = 1'b0;
        set_req2(0, OP_IMM, 7'd0, 32'd5, 32'd0, 32'd7);
        b2.req_valid = 2'b01;
        #1;
        chk("t1_req_ready", b2.req_ready, 2'b01);
        chk("t1_busy_idle", busy2, 0);
        tick();
        b2.req_valid = 2'b00;
        chk("t1_busy_exec", busy2, 1);
        chk("t1_rsp_valid_exec", b2.rsp_valid, 2'b00);
        chk("t1_alu_rrs1", a2, 5);
        chk("t1_alu_imm", i2, 7);
        tick();
        chk("t1_rsp_valid", b2.rsp_valid, 2'b01);
        chk("t1_rsp_res", b2.rsp_res, 12);
        chk("t1_busy_resp", busy2, 1);
        b2.rsp_ready = 2'b01;
        tick();
        b2.rsp_ready = 2'b00;
        chk("t1_busy_done", busy2, 0);
        chk("t1_rsp_valid_done", b2.rsp_valid, 2'b00);

        // contention: both valid, requester 0 first after reset
        do_reset();
        set_req2(0, OP, 7'd0, 32'd1, 32'd2, 32'd0);
        set_req2(1, OP, 7'd0, 32'd10, 32'd20, 32'd0);
        b2.req_valid = 2'b11;
        #1;
        chk("t2_grant0", b2.req_ready, 2'b01);
        tick();
        chk("t2_exec_no_ready", b2.req_ready, 2'b00);
        tick();
        chk("t2_rsp_valid0", b2.rsp_valid, 2'b01);
        chk("t2_rsp_res0", b2.rsp_res, 3);
        b2.rsp_ready = 2'b11;
        #1;
        chk("t2_resp_ready", b2.req_ready, BYP_RDY);
        tick();
`ifndef ALU_ARB_BYPASS_EN
        chk("t2_grant1", b2.req_ready, 2'b10);
        tick();
`endif
        chk("t2_exec1_busy", busy2, 1);
        tick();
        chk("t2_rsp_valid1", b2.rsp_valid, 2'b10);
        chk("t2_rsp_res1", b2.rsp_res, 30);
        tick();
        b2.req_valid = 2'b00;
        b2.rsp_ready = 2'b00;

        // response backpressure: SUB 9-4 held while owner not ready
        do_reset();
        set_req2(0, OP, 7'h20, 32'd9, 32'd4, 32'd0);
        b2.req_valid = 2'b01;
        tick();
        b2.req_valid = 2'b00;
        tick();
        set_req2(1, OP, 7'd0, 32'd3, 32'd3, 32'd0);
        b2.req_valid = 2'b10;
        b2.rsp_ready = 2'b10;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("t3_rsp_valid_hold", b2.rsp_valid, 2'b01);
            chk("t3_rsp_res_hold", b2.rsp_res, 5);
            chk("t3_req_ready_hold", b2.req_ready, 2'b00);
            tick();
        end
        b2.rsp_ready = 2'b01;
        #1;
        chk("t3_resp_ready", b2.req_ready, BYP_RDY);
        tick();
        chk("t3_rsp_valid_done", b2.rsp_valid, 2'b00);
        b2.req_valid = 2'b00;
        b2.rsp_ready = 2'b00;

        // reset in EXEC drops the op and clears rr_ptr
        do_reset();
        set_req2(0, OP_IMM, 7'd0, 32'd1, 32'd0, 32'd1);
        b2.req_valid = 2'b01;
        tick();
        b2.req_valid = 2'b00;
        b2.rsp_ready = 2'b11;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("t4_busy", busy2, 0);
        chk("t4_rsp_valid", b2.rsp_valid, 2'b00);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("t4_no_rsp", {busy2, b2.rsp_valid}, 3'b000);
        end
        b2.rsp_ready = 2'b00;
        b2.req_valid = 2'b11;
        #1;
        chk("t4_rr_ptr0", b2.req_ready, 2'b01);
        b2.req_valid = 2'b00;
        tick();

        // fairness and accept spacing on the 3-requester instance
        for (int i = 0; i < 3; i++) begin
            b3.req_instr_type[5*i +: 5]     = OP;
            b3.req_rrs1[XLEN*i +: XLEN]     = XLEN'(i);
            b3.req_rrs2[XLEN*i +: XLEN]     = 32'd100;
        end
        b3.req_valid = 3'b111;
        b3.rsp_ready = 3'b111;
        ng = 0;
        for (int cyc = 0; cyc < 100 && ng < 9; cyc++) begin
            #1;
            if (b3.rsp_valid != 3'b000 && ng > 0) begin
                chk("t5_rsp_owner", b3.rsp_valid, 3'b001 << grant[ng-1]);
                chk("t5_rsp_res", b3.rsp_res, 100 + grant[ng-1]);
            end
            if (b3.req_ready != 3'b000) begin
                gi = -1;
                for (int i = 0; i < 3; i++) if (b3.req_ready[i]) gi = i;
                grant[ng] = gi;
                gcyc[ng]  = cyc;
                ng++;
            end
            tick();
        end
        chk("t5_grant_count", ng, 9);
        for (int k = 0; k < ng; k++) begin
            chk("t5_grant_order", grant[k], k % 3);
            if (k > 0) chk("t5_accept_gap", gcyc[k] - gcyc[k-1], GAP);
        end
        b3.req_valid = 3'b000;
        b3.rsp_ready = 3'b000;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
